// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage for a single-cycle MIPS datapath. Holds the PC and
//   the instruction memory, presents IR to the downstream stages and computes
//   the next PC (sequential or BEQ target) from the Branch/Zero feedback.
//   A run-control FSM (IDLE / RUN / HALT) gates program load, execution and
//   a clean stop on the halt sentinel or an out-of-range PC.
//
//   All state updates happen on the FALLING edge of clock, in step with the
//   CPU's PC register.
//
// Ports
//   clock      in   single clock, state updates on negedge
//   reset      in   synchronous, active-high, sampled on negedge
//   prog_we    in   program-load write enable (IDLE only)
//   prog_addr  in   [AW-1:0] word address for program load
//   prog_data  in   [31:0] instruction word to load
//   start      in   begin execution from address 0 (IDLE only)
//   stall      in   hold PC and IR this cycle (RUN only)
//   branch     in   Branch bit from main control for the current IR
//   zero       in   ALU Zero flag for the current IR
//   IR         out  [31:0] current instruction (0 while IDLE)
//   PC         out  [31:0] current program counter (byte address)
//   NextPC     out  [31:0] PC to be loaded at the next unstalled edge
//   running    out  high in RUN
//   halted     out  high in HALT
//   fault      out  high in HALT when the halt came from an out-of-range PC
//
// Handshake: there is no valid/ready pair here; start and prog_we are
// single-cycle strobes sampled at the falling edge, and stall is a level
// that freezes PC/IR for every falling edge it is high during RUN.
//
// DEPTH must be a power of two and AW must equal log2(DEPTH).
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          start,
  input  logic          stall,
  input  logic          branch,
  input  logic          zero,
  output logic [31:0]   IR,
  output logic [31:0]   PC,
  output logic [31:0]   NextPC,
  output logic          running,
  output logic          halted,
  output logic          fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

  logic [31:0] r_mem [DEPTH];

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_fault;
  logic        w_fault_next;

  logic [31:0] w_ir_raw;
  logic [31:0] w_ir;
  logic [31:0] w_imm;
  logic [31:0] w_seq;
  logic [31:0] w_tgt;
  logic [31:0] w_next_pc;
  logic        w_out_of_range;

  // Combinational read. In HALT the PC is frozen and memory cannot be
  // written, so the same read naturally holds IR without a separate register.
  assign w_ir_raw = r_mem[r_pc[AW+1:2]];
  assign w_ir     = (r_state == S_IDLE) ? 32'd0 : w_ir_raw;

  assign w_imm     = {{14{w_ir[15]}}, w_ir[15:0], 2'b00};
  assign w_seq     = r_pc + 32'd4;
  assign w_tgt     = w_seq + w_imm;
  assign w_next_pc = (branch && zero) ? w_tgt : w_seq;

  // NextPC >= 4*DEPTH exactly when any bit above the byte-address range is
  // set; negative targets wrap to large unsigned values and are caught too.
  assign w_out_of_range = |w_next_pc[31:AW+2];

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_fault_next = r_fault;
    unique case (r_state)
      S_IDLE: begin
        w_pc_next    = 32'd0;
        w_fault_next = 1'b0;
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          // Sentinel takes priority over the range check.
          if (w_ir == SENTINEL) begin
            w_state_next = S_HALT;
            w_fault_next = 1'b0;
          end else if (w_out_of_range) begin
            w_state_next = S_HALT;
            w_fault_next = 1'b1;
          end else begin
            w_pc_next = w_next_pc;
          end
        end
      end
      S_HALT: begin
        // Everything holds until reset.
      end
      default: begin
        w_state_next = S_IDLE;
        w_pc_next    = 32'd0;
        w_fault_next = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= 32'd0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_fault <= w_fault_next;
    end
  end

  // Program memory survives reset; writes are accepted only while IDLE.
  always_ff @(negedge clock) begin
    if ((r_state == S_IDLE) && prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  assign IR      = w_ir;
  assign PC      = r_pc;
  assign NextPC  = w_next_pc;
  assign running = (r_state == S_RUN);
  assign halted  = (r_state == S_HALT);
  assign fault   = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // main instance (DEPTH 1024)
  logic        reset = 1'b1;
  logic        prog_we = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] IR, PC, NextPC;
  logic        running, halted, fault;

  instr_fetch #(.DEPTH(1024), .AW(10)) dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stall(stall), .branch(branch),
    .zero(zero), .IR(IR), .PC(PC), .NextPC(NextPC), .running(running),
    .halted(halted), .fault(fault)
  );

  // small instance (DEPTH 4) for the run-off-the-top case
  logic        d_reset = 1'b1;
  logic        d_prog_we = 1'b0;
  logic [1:0]  d_prog_addr = '0;
  logic [31:0] d_prog_data = '0;
  logic        d_start = 1'b0;
  logic [31:0] d_IR, d_PC, d_NextPC;
  logic        d_running, d_halted, d_fault;

  instr_fetch #(.DEPTH(4), .AW(2)) dut_small (
    .clock(clock), .reset(d_reset), .prog_we(d_prog_we), .prog_addr(d_prog_addr),
    .prog_data(d_prog_data), .start(d_start), .stall(1'b0), .branch(1'b0),
    .zero(1'b0), .IR(d_IR), .PC(d_PC), .NextPC(d_NextPC), .running(d_running),
    .halted(d_halted), .fault(d_fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 run, 2 halt. PC kept as a plain integer.
  localparam longint TWO32 = 64'sh1_0000_0000;
  logic [31:0] m_mem [1024];
  int          m_mode = 0;
  longint      m_pc = 0;
  bit          m_fault = 0;

  function automatic logic [31:0] m_ir();
    if (m_mode == 0) return 32'd0;
    return m_mem[int'(m_pc / 4)];
  endfunction

  function automatic longint m_next();
    logic [31:0] ir;
    int          off;
    longint      t;
    ir = m_ir();
    off = $signed(ir[15:0]);
    t = m_pc + 4;
    if (branch && zero) t = t + 4 * longint'(off);
    if (t < 0) t = t + TWO32;
    if (t >= TWO32) t = t - TWO32;
    return t;
  endfunction

  // Apply one falling edge to the model using the current input values.
  task automatic m_edge();
    logic [31:0] ir;
    longint      nx;
    ir = m_ir();
    nx = m_next();
    if (m_mode == 0 && prog_we) m_mem[prog_addr] = prog_data;
    if (reset) begin
      m_mode = 0; m_pc = 0; m_fault = 0;
    end else if (m_mode == 0) begin
      m_pc = 0;
      if (start) m_mode = 1;
    end else if (m_mode == 1 && !stall) begin
      if (ir == 32'hFFFF_FFFF) begin
        m_mode = 2; m_fault = 0;
      end else if (nx >= 4 * 1024) begin
        m_mode = 2; m_fault = 1;
      end else begin
        m_pc = nx;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after the rising edge; outputs are sampled there too,
  // well away from the active falling edge.
  task automatic tick();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic step();
    m_edge();
    tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},      PC,      32'(m_pc));
    chk({tag, ".ir"},      IR,      m_ir());
    chk({tag, ".nextpc"},  NextPC,  32'(m_next()));
    chk({tag, ".running"}, {31'd0, running}, {31'd0, (m_mode == 1)});
    chk({tag, ".halted"},  {31'd0, halted},  {31'd0, (m_mode == 2)});
    chk({tag, ".fault"},   {31'd0, fault},   {31'd0, m_fault});
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    int          r;
    int          off;
    logic [31:0] w;
    r = $urandom_range(0, 99);
    if (r < 3) begin
      w = 32'hFFFF_FFFF;
    end else if (r < 28) begin
      off = $urandom_range(0, 16);
      off = off - 6;
      w = {16'h1000, 16'(off)};
    end else begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'd0;
    end
    return w;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] word;
    logic        br;
    logic        z;
    logic [31:0] exp_next;
    logic        exp_halt;
    logic        exp_fault;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] seq_ir[3];
    logic [31:0] ir_m;

    vecs[0] = '{32'h1000_0002, 1'b1, 1'b1, 32'd12,          1'b0, 1'b0, 32'd12};
    vecs[1] = '{32'h1000_0002, 1'b1, 1'b0, 32'd4,           1'b0, 1'b0, 32'd4};
    vecs[2] = '{32'h1000_FFFC, 1'b1, 1'b1, 32'hFFFF_FFF4,   1'b1, 1'b1, 32'd0};
    vecs[3] = '{32'h1000_FFFF, 1'b1, 1'b1, 32'd0,           1'b0, 1'b0, 32'd0};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 32'd4,           1'b1, 1'b0, 32'd0};
    vecs[5] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 32'd4,           1'b1, 1'b0, 32'd0};
    vecs[6] = '{32'h1000_03FF, 1'b1, 1'b1, 32'd4096,        1'b1, 1'b1, 32'd0};
    vecs[7] = '{32'h1000_03FE, 1'b1, 1'b1, 32'd4092,        1'b0, 1'b0, 32'd4092};
    vecs[8] = '{32'h1000_0000, 1'b1, 1'b1, 32'd4,           1'b0, 1'b0, 32'd4};
    vecs[9] = '{32'h1000_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFC,   1'b1, 1'b1, 32'd0};

    @(posedge clock);
    #1;

    // reset values
    do_reset();
    chk("rst.pc", PC, 32'd0);
    chk("rst.ir", IR, 32'd0);
    chk("rst.nextpc", NextPC, 32'd4);
    chk("rst.running", {31'd0, running}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);

    // fill the whole memory so every read is defined
    for (int a = 0; a < 1024; a++) load(10'(a), rand_word());

    // --- load and run sequentially ---
    load(10'd0, 32'h2009_000f);
    load(10'd1, 32'h200a_0007);
    load(10'd2, 32'hFFFF_FFFF);
    do_start();
    chk("seq.ir0", IR, 32'h2009_000f);
    chk("seq.run", {31'd0, running}, 32'd1);
    step(); chk("seq.ir1", IR, 32'h200a_0007);
    step(); chk("seq.ir2", IR, 32'hFFFF_FFFF);
    step();
    chk("seq.halted", {31'd0, halted}, 32'd1);
    chk("seq.fault", {31'd0, fault}, 32'd0);
    chk("seq.pc", PC, 32'd8);
    start = 1'b1; prog_we = 1'b1; prog_addr = 10'd2; prog_data = 32'd0; stall = 1'b1;
    step();
    start = 1'b0; prog_we = 1'b0; stall = 1'b0;
    chk("seq.pc_hold", PC, 32'd8);
    chk("seq.ir_hold", IR, 32'hFFFF_FFFF);
    chk("seq.halt_hold", {31'd0, halted}, 32'd1);

    // --- taken branch ---
    do_reset();
    load(10'd0, 32'h2000_0000);
    load(10'd1, 32'h1000_0002);
    load(10'd2, 32'h1111_1111);
    load(10'd3, 32'h2222_2222);
    load(10'd4, 32'h3c01_1234);
    do_start();
    step();
    chk("tk.pc4", PC, 32'd4);
    branch = 1'b1; zero = 1'b1; #1;
    chk("tk.nextpc", NextPC, 32'd16);
    step();
    branch = 1'b0; zero = 1'b0;
    chk("tk.pc16", PC, 32'd16);
    chk("tk.ir", IR, 32'h3c01_1234);

    // --- not-taken branch (program intact across reset) ---
    do_reset();
    do_start();
    step();
    branch = 1'b1; zero = 1'b0; #1;
    chk("nt.nextpc", NextPC, 32'd8);
    step();
    branch = 1'b0;
    chk("nt.ir", IR, 32'h1111_1111);

    // --- stall for three cycles at PC 4 ---
    do_reset();
    do_start();
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("st.pc", PC, 32'd4);
      chk("st.ir", IR, 32'h1000_0002);
    end
    stall = 1'b0;
    step();
    chk("st.pc8", PC, 32'd8);

    // --- stall + branch: stall wins, zero sampled on the unstalled edge ---
    do_reset();
    do_start();
    step();
    stall = 1'b1; branch = 1'b1; zero = 1'b0;
    step();
    chk("sb.pc_hold", PC, 32'd4);
    stall = 1'b0; zero = 1'b1;
    step();
    branch = 1'b0; zero = 1'b0;
    chk("sb.pc16", PC, 32'd16);

    // --- reset mid-run at PC 8, then replay; writes during RUN ignored ---
    do_reset();
    do_start();
    prog_we = 1'b1; prog_addr = 10'd0; prog_data = 32'hDEAD_BEEF;
    step();
    prog_we = 1'b0;
    step();
    chk("rr.pc8", PC, 32'd8);
    do_reset();
    chk("rr.pc0", PC, 32'd0);
    chk("rr.ir0", IR, 32'd0);
    chk("rr.idle", {31'd0, running}, 32'd0);
    seq_ir[0] = 32'h2000_0000; seq_ir[1] = 32'h1000_0002; seq_ir[2] = 32'h1111_1111;
    do_start();
    for (int k = 0; k < 3; k++) begin
      chk("rr.replay", IR, seq_ir[k]);
      step();
    end

    // --- table of single-branch vectors at PC 0 ---
    foreach (vecs[i]) begin
      do_reset();
      load(10'd0, vecs[i].word);
      do_start();
      branch = vecs[i].br; zero = vecs[i].z; #1;
      chk($sformatf("vec%0d.nextpc", i), NextPC, vecs[i].exp_next);
      step();
      branch = 1'b0; zero = 1'b0;
      chk($sformatf("vec%0d.halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halt});
      chk($sformatf("vec%0d.fault", i), {31'd0, fault}, {31'd0, vecs[i].exp_fault});
      chk($sformatf("vec%0d.pc", i), PC, vecs[i].exp_pc);
      chk($sformatf("vec%0d.ir", i), IR, m_ir());
    end

    // --- run-off the top with DEPTH 4 ---
    tick();
    d_reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      d_prog_we = 1'b1; d_prog_addr = 2'(a); d_prog_data = 32'h2000_0001 + 32'(a);
      tick();
    end
    d_prog_we = 1'b0;
    d_start = 1'b1; tick(); d_start = 1'b0;
    chk("ro.pc0", d_PC, 32'd0);
    tick(); chk("ro.pc4", d_PC, 32'd4);
    tick(); chk("ro.pc8", d_PC, 32'd8);
    tick(); chk("ro.pc12", d_PC, 32'd12);
    chk("ro.ir3", d_IR, 32'h2000_0004);
    chk("ro.next16", d_NextPC, 32'd16);
    tick();
    chk("ro.halted", {31'd0, d_halted}, 32'd1);
    chk("ro.fault", {31'd0, d_fault}, 32'd1);
    chk("ro.pc_hold", d_PC, 32'd12);

    // --- randomized runs against the model ---
    for (int t = 0; t < 30; t++) begin
      for (int a = 0; a < 8; a++) load(10'($urandom_range(0, 63)), rand_word());
      do_start();
      check_all("rnd.start");
      for (int c = 0; c < 150; c++) begin
        ir_m = m_ir();
        stall     = ($urandom_range(0, 4) == 0);
        zero      = 1'($urandom_range(0, 1));
        branch    = (ir_m[31:26] == 6'b000100);
        prog_we   = ($urandom_range(0, 9) == 0);
        prog_addr = 10'($urandom_range(0, 1023));
        prog_data = rand_word();
        start     = ($urandom_range(0, 9) == 0);
        reset     = ($urandom_range(0, 199) == 0);
        step();
        check_all("rnd");
      end
      stall = 1'b0; branch = 1'b0; zero = 1'b0; prog_we = 1'b0; start = 1'b0;
      do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle MIPS datapath. It holds the PC and the instruction memory, and it supplies `IR` to the decode, register-file and ALU stage. It also computes the sequential and BEQ branch-target next PC from the `Branch` and `Zero` feedback. A small run-control FSM sequences operation: programs are loaded while idle, execution runs from address 0, and fetch stops cleanly on a halt sentinel or an out-of-range PC.

## Interface
Parameters:
- `DEPTH`, 1024: instruction memory size in 32-bit words. Must be a power of two.
- `AW`, 10: word-address width. Must equal log2(`DEPTH`).

Ports:
- `clock`, input, 1: single clock. All state updates on the falling edge of `clock`, aligned with the CPU's PC update.
- `reset`, input, 1: synchronous, active-high. Sampled on the falling edge.
- `prog_we`, input, 1: program-load write enable. Honoured only in IDLE.
- `prog_addr`, input, `AW`: word address for the program load.
- `prog_data`, input, 32: instruction word to load.
- `start`, input, 1: begin execution. Honoured only in IDLE.
- `stall`, input, 1: hold the PC and `IR` for this cycle. Honoured only in RUN.
- `branch`, input, 1: the `Branch` bit from main control for the current `IR`.
- `zero`, input, 1: the ALU `Zero` flag for the current `IR`.
- `IR`, output, 32: current instruction.
- `PC`, output, 32: current program counter (byte address).
- `NextPC`, output, 32: the PC value that will be loaded at the next falling edge if not stalled.
- `running`, output, 1: high while in RUN.
- `halted`, output, 1: high while in HALT.
- `fault`, output, 1: high in HALT when the halt was caused by an out-of-range PC.

## Operation
- **States and transitions:**
  - IDLE to RUN on `start`.
  - RUN to HALT on a halt condition.
  - Any state to IDLE on `reset`.
- **IDLE:**
  - `prog_we` writes `prog_data` into `mem[prog_addr]`.
  - PC = 0.
  - `IR` is forced to 0 (a nop).
  - `start` and `prog_we` may be asserted in the same cycle. The write still happens, then the block enters RUN with PC = 0.
- **RUN:**
  - `IR` = `mem[PC[AW+1:2]]`. This is a combinational read.
  - `PC[1:0]` is always 0.
  - seq = PC + 4.
  - tgt = PC + 4 + (sign-extend(`IR[15:0]`) << 2), computed modulo 2^32.
  - `NextPC` = tgt if `branch` and `zero` are both high, otherwise seq.
  - On a falling edge with `stall` low, PC <= `NextPC`.
  - On a falling edge with `stall` high, PC holds. `NextPC` is still driven.
- **Halt conditions in RUN,** evaluated at the falling edge and only when `stall` is low:
  - `IR` == 32'hFFFFFFFF is the sentinel. Go to HALT with PC held and `fault` = 0.
  - Otherwise, if `NextPC` >= 4·`DEPTH`, go to HALT with PC held and `fault` = 1. This covers sequential run-off at the top and out-of-range branch targets, including negative targets, which wrap to large unsigned values.
  - The sentinel check has priority over the range check.
- **HALT:**
  - PC, `IR` and `fault` hold.
  - `prog_we`, `start` and `stall` are ignored.
  - Only `reset` exits.
- **Memory and reset:**
  - Memory contents are not cleared by reset.
  - Memory is writable only in IDLE.
- **Control from downstream:** the block does not decode opcodes. `branch` must be 0 for non-BEQ instructions, as guaranteed by main control.

## Timing
- **Values after reset, at the first falling edge with `reset` high:** state IDLE, PC = 0, `IR` = 0, `running` = 0, `halted` = 0, `fault` = 0. `NextPC` = 4 (combinational, don't-care in IDLE).
- **Start:** `start` is sampled at edge n. `running` = 1 and `IR` = `mem[0]` after edge n.
- **Instruction rate:** one instruction per clock period. `IR` changes only just after a falling edge.
- **Reset mid-RUN or mid-HALT:** reset at edge n puts the block in IDLE after edge n. Any pending branch or stall is discarded.
- **Stall and branch together:** `stall` wins. The branch resolves on the first unstalled edge, using the `zero` value present at that edge.
- **Load latency:** a program write is visible in `mem` at the next edge. Read-after-write in IDLE is not exposed because `IR` is forced to 0.

## Test plan
- **Load and run sequentially:**
  - Stimulus: load words 0–2 = 2009000f, 200a0007, FFFFFFFF, then pulse `start`.
  - Required: `IR` sequence 2009000f, 200a0007, FFFFFFFF on successive cycles, then `halted` = 1, `fault` = 0, PC = 8 holding.
- **Taken branch:**
  - Stimulus: word 1 = 1000_0002 (BEQ, offset 2), with `branch` = 1 and `zero` = 1 while PC = 4.
  - Required: `NextPC` = 16, and the next `IR` = `mem[4]`.
- **Not-taken branch:**
  - Stimulus: same as the taken-branch case but `zero` = 0.
  - Required: `NextPC` = 8.
- **Stall:**
  - Stimulus: hold `stall` for 3 cycles at PC = 4.
  - Required: PC = 4 and `IR` stable for 3 cycles, then PC = 8.
- **Out-of-range and run-off:**
  - Stimulus A: branch with offset 16'hFFFC at PC = 0 (target −12).
  - Required A: HALT, `fault` = 1, PC = 0.
  - Stimulus B: with `DEPTH` = 4 and no sentinel, run off the top.
  - Required B: HALT at PC = 12 with `fault` = 1.
- **Reset and gating:**
  - Stimulus: assert `reset` during RUN at PC = 8.
  - Required: after that edge, IDLE, PC = 0, `IR` = 0. The program is still intact, shown by a re-`start` replaying the same `IR` sequence.
  - Stimulus: assert `prog_we` during RUN.
  - Required: memory unchanged.
